ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port synchronous 16KB system RAM between the 65C02 (primary) and a secondary bus master (DMA/debug loader).
- Sits between address decode and the RAM instance.
- Steals cycles invisibly when the CPU is not addressing RAM; otherwise stalls the CPU via RDY.
- A stall counter bounds CPU starvation.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width.
- DATA_WIDTH, 8, data bus width.
- MAX_CPU_STALL, 4, maximum consecutive CPU stall cycles before the CPU is forced one slot; range 1..15.

Ports:
- clk  in  1  CPU-domain clock (divided clock)
- reset  in  1  synchronous, active-high reset
- cpu_ram_cs  in  1  CPU is addressing RAM this cycle (registered-address decode)
- cpu_addr  in  ADDR_WIDTH  CPU RAM address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdy  out  1  CPU ready; 0 stalls the CPU
- cpu_rdata  out  DATA_WIDTH  RAM read data to the CPU data-in mux
- dma_req  in  1  secondary master requests an access this cycle
- dma_addr  in  ADDR_WIDTH  secondary master address
- dma_we  in  1  secondary master write
- dma_wdata  in  DATA_WIDTH  secondary master write data
- dma_gnt  out  1  access accepted this cycle; transfer = dma_req & dma_gnt
- dma_rdata  out  DATA_WIDTH  read data
- dma_rvalid  out  1  dma_rdata valid
- ram_cs  out  1  RAM chip select
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle latency after address

Behaviour:
- Reset values:
  - stall_cnt = 0, force_cpu = 0, rd_pending = 0.
  - dma_rvalid = 0, dma_gnt = 0, cpu_rdy = 1.
  - ram_cs = 0, ram_we = 0.
- Grant decision is combinational per cycle from the current inputs and registered state:
  - dma_gnt = dma_req & ~reset & (~cpu_ram_cs | (~force_cpu & stall_cnt < MAX_CPU_STALL)).
  - cpu_rdy = ~(cpu_ram_cs & dma_gnt).
- RAM port mux:
  - If dma_gnt: ram_addr/we/wdata come from dma_*, and ram_cs = 1.
  - Otherwise: they come from cpu_*, with ram_cs = cpu_ram_cs and ram_we = cpu_we & cpu_ram_cs.
  - A CPU write is never issued to RAM in a stalled cycle.
- stall_cnt (registered):
  - Increments when cpu_ram_cs & dma_gnt.
  - Clears when cpu_ram_cs & ~dma_gnt (CPU served) or when ~cpu_ram_cs.
  - Saturates at MAX_CPU_STALL.
- force_cpu (registered):
  - Set on the cycle stall_cnt reaches MAX_CPU_STALL.
  - While set, the CPU owns the next RAM cycle regardless of dma_req.
  - Cleared after the CPU is served, or when cpu_ram_cs drops.
- Read return:
  - rd_pending <= dma_gnt & ~dma_we.
  - dma_rvalid = rd_pending (registered, 1 cycle after the granted read).
  - dma_rdata = ram_rdata.
- cpu_rdata = ram_rdata unconditionally. The CPU re-presents its address while stalled, so stale data is never consumed.
- Idle behaviour:
  - No cpu_ram_cs: DMA is granted every requesting cycle (back-to-back unlimited); cpu_rdy stays 1.
  - No dma_req: pure pass-through; cpu_rdy = 1.
- Simultaneous request, stall_cnt = 0: DMA wins the first cycle. The CPU is guaranteed service after at most MAX_CPU_STALL stalled cycles.
- Reset mid-operation: a pending read is dropped (dma_rvalid = 0 next cycle) and counters clear. A DMA write granted in the reset cycle is not issued, because dma_gnt is forced to 0 during reset.
- MAX_CPU_STALL width: the counter is 4 bits. Values outside 1..15 are flagged by an elaboration-time check.

Decomposition:
- Shared package arb_pkg:
  - RAM_ADDR_WIDTH = 14, DATA_WIDTH = 8.
  - Stall-counter width constant.
  - Owner enum: OWN_CPU, OWN_DMA.
- Sub-module: none. The stall/force logic fits in one module.
- An optional checker, ram_arbiter_sva, is bound in simulation to assert the starvation bound and single-owner RAM access.

Test Plan:
- Pass-through: no dma_req; CPU writes 0x5A to 0x0123, then reads it back → ram_we pulses once, cpu_rdata = 0x5A the following cycle, cpu_rdy stays 1.
- Invisible steal: cpu_ram_cs = 0, DMA writes 0x11..0x18 to 0x0200..0x0207 back-to-back → dma_gnt = 1 for 8 cycles, cpu_rdy = 1 throughout, RAM contents verified.
- Starvation bound (MAX_CPU_STALL = 4): cpu_ram_cs and dma_req held high continuously → pattern of 4 DMA grants with cpu_rdy = 0, then 1 cycle with cpu_rdy = 1 and dma_gnt = 0, repeating; stall never exceeds 4.
- DMA read latency: DMA reads 0x0300 holding 0xA7 → dma_rvalid = 1 exactly one cycle after the grant with dma_rdata = 0xA7; no rvalid after a DMA write.
- Stalled CPU write suppressed: CPU writes 0x33 to 0x0010 while DMA writes 0x44 to 0x0010 in the same cycle → DMA's 0x44 lands first; the CPU write completes only in its granted cycle, final value 0x33.
- Reset mid-read: assert reset in the cycle after a granted DMA read → dma_rvalid = 0; after release cpu_rdy = 1 and stall_cnt = 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the system-RAM arbiter between the 65C02
// and the secondary bus master.
package arb_pkg;

  localparam int RAM_ADDR_WIDTH = 14;
  localparam int DATA_WIDTH     = 8;
  localparam int STALL_CNT_W    = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the secondary master steals idle CPU cycles and may
// stall the CPU through cpu_rdy for at most MAX_CPU_STALL consecutive cycles.
module ram_arbiter #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_CPU_STALL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_ram_cs,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_we,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic                  ram_cs,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  import arb_pkg::*;

  if (MAX_CPU_STALL < 1 || MAX_CPU_STALL > 15) begin : g_bad_max_stall
    $error("ram_arbiter: MAX_CPU_STALL must be in 1..15");
  end

  localparam logic [STALL_CNT_W-1:0] MAX_CNT = STALL_CNT_W'(MAX_CPU_STALL);

  logic [STALL_CNT_W-1:0] stall_cnt, stall_nxt;
  logic                   force_cpu, force_nxt;
  logic                   rd_pending;
  owner_e                 owner;
  logic                   cpu_stalled;

  // Handshake: a DMA transfer happens in any cycle with dma_req & dma_gnt;
  // read data follows one cycle later qualified by dma_rvalid. The CPU side
  // has no valid, it simply holds its request while cpu_rdy is low.
  always_comb begin
    dma_gnt     = dma_req & ~reset &
                  (~cpu_ram_cs | (~force_cpu & (stall_cnt < MAX_CNT)));
    owner       = dma_gnt ? OWN_DMA : OWN_CPU;
    cpu_stalled = cpu_ram_cs & dma_gnt;
    cpu_rdy     = ~cpu_stalled;

    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    case (owner)
      OWN_DMA: begin
        ram_cs    = 1'b1;
        ram_we    = dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      default: begin
        // Keep the RAM quiet while reset is held, whatever the CPU decode says.
        ram_cs = cpu_ram_cs & ~reset;
        ram_we = cpu_we & cpu_ram_cs & ~reset;
      end
    endcase

    stall_nxt = '0;
    if (cpu_stalled)
      stall_nxt = (stall_cnt == MAX_CNT) ? MAX_CNT : stall_cnt + 1'b1;

    force_nxt = 1'b0;
    if (cpu_stalled)
      force_nxt = (stall_nxt == MAX_CNT) ? 1'b1 : force_cpu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      force_cpu  <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      stall_cnt  <= stall_nxt;
      force_cpu  <= force_nxt;
      rd_pending <= dma_gnt & ~dma_we;
    end
  end

  assign dma_rvalid = rd_pending;
  assign dma_rdata  = ram_rdata;
  assign cpu_rdata  = ram_rdata;

endmodule
